// File: rtl/bram_delay_pkg.sv
// Shared definitions for the BRAM delay line.
//   ERRCNT_W    : width of the saturating BIST mismatch counter
//   RD_LAT      : accept-to-output latency (registered BRAM read + output register)
//   sample_t    : default per-channel sample type
//   clamp_delay : maps a programmed delay of 0 to 1
package bram_delay_pkg;

  localparam int unsigned ERRCNT_W = 16;
  localparam int unsigned RD_LAT   = 2;
  localparam int unsigned SAMPLE_W = 32;

  typedef logic [SAMPLE_W-1:0] sample_t;

  function automatic int unsigned clamp_delay(input int unsigned x);
    return (x == 0) ? 1 : x;
  endfunction

endpackage

// File: rtl/bram_sdp.sv
// Simple dual-port RAM, one write port and one registered read port, inferred as block RAM.
//   clk_i   : clock
//   we_i    : write enable;  waddr_i / wdata_i : write address / data
//   re_i    : read enable;   raddr_i           : read address
//   rdata_o : read data, valid the cycle after re_i, held while re_i is low
module bram_sdp #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 1024,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // No reset: keeps the array mappable onto block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/bram_delay_line.sv
// Multi-channel programmable sample delay built on one block RAM, with a built-in
// pattern generator / checker for RAM integrity testing.
//   clk, reset            : clock, asynchronous active-high reset
//   cfg_delay, cfg_load   : delay in samples (0 acts as 1), load pulse restarts the fill
//   bist_en               : internal pattern source and checker replace in_valid/in_data
//   in_valid, in_data     : input sample strobe and CH packed channels
//   out_valid, out_data   : delayed sample strobe and channels (data held between strobes)
//   filled                : buffer holds at least delay samples
//   err_clear             : clears error and err_count
//   error, err_count      : sticky BIST mismatch flag and saturating mismatch count
module bram_delay_line
  import bram_delay_pkg::*;
#(
  parameter int unsigned DATA_W = $bits(sample_t),
  parameter int unsigned CH     = 2,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned SEED   = 500,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [AW-1:0]          cfg_delay,
  input  logic                   cfg_load,
  input  logic                   bist_en,
  input  logic                   in_valid,
  input  logic [CH*DATA_W-1:0]   in_data,
  output logic                   out_valid,
  output logic [CH*DATA_W-1:0]   out_data,
  output logic                   filled,
  input  logic                   err_clear,
  output logic                   error,
  output logic [ERRCNT_W-1:0]    err_count
);

  localparam int unsigned W = CH * DATA_W;
  typedef logic [DATA_W-1:0] chan_t;
  localparam chan_t SEED_V = chan_t'(SEED);

  logic                acc;
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       delay_q, delay_d;
  logic [AW-1:0]       fill_cnt_q, fill_cnt_d;
  logic [AW-1:0]       rd_addr;
  chan_t               gen_base_q, gen_base_d, gen_cur;
  chan_t               chk_base_q, chk_base_d;
  logic [W-1:0]        wr_data, rd_data;
  logic [W-1:0]        out_data_q, out_data_d;
  logic [RD_LAT-1:0]   vld_q, vld_d;
  logic                mismatch;
  logic                error_q, error_d;
  logic [ERRCNT_W-1:0] err_count_q, err_count_d;

  assign acc       = bist_en | in_valid;
  // delay_q >= 1, so the read address never equals the write address.
  assign rd_addr   = wr_ptr_q - delay_q;
  assign filled    = (fill_cnt_q == delay_q);
  assign out_valid = vld_q[RD_LAT-1];
  assign out_data  = out_data_q;
  assign error     = error_q;
  assign err_count = err_count_q;

  // A load cycle's own sample is the first of the new fill, so it already uses the seed.
  always_comb begin
    gen_cur = cfg_load ? SEED_V : gen_base_q;
    wr_data = in_data;
    if (bist_en) begin
      for (int unsigned c = 0; c < CH; c++) begin
        wr_data[c*DATA_W +: DATA_W] = gen_cur + chan_t'(c);
      end
    end
  end

  // Reads the output port so a mismatch injected on out_data is seen by the checker.
  always_comb begin
    mismatch = 1'b0;
    for (int unsigned c = 0; c < CH; c++) begin
      if (out_data[c*DATA_W +: DATA_W] != chk_base_q + chan_t'(c)) mismatch = 1'b1;
    end
    mismatch = mismatch & out_valid & bist_en;
  end

  always_comb begin
    wr_ptr_d    = acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
    delay_d     = cfg_load ? AW'(clamp_delay(32'(cfg_delay))) : delay_q;
    gen_base_d  = acc ? gen_cur + chan_t'(1) : gen_cur;

    fill_cnt_d = fill_cnt_q;
    if (cfg_load)          fill_cnt_d = acc ? AW'(1) : '0;
    else if (acc && !filled) fill_cnt_d = fill_cnt_q + AW'(1);

    chk_base_d = chk_base_q;
    if (cfg_load)                  chk_base_d = SEED_V;
    else if (out_valid && bist_en) chk_base_d = chk_base_q + chan_t'(1);

    // Load squashes everything in flight, including the stage about to reach the output.
    vld_d      = {vld_q[RD_LAT-2:0], acc & filled} & {RD_LAT{~cfg_load}};
    out_data_d = vld_d[RD_LAT-1] ? rd_data : out_data_q;

    error_d     = error_q;
    err_count_d = err_count_q;
    if (mismatch) begin
      error_d = 1'b1;
      if (err_clear)                 err_count_d = ERRCNT_W'(1);
      else if (err_count_q != '1)    err_count_d = err_count_q + ERRCNT_W'(1);
    end else if (err_clear) begin
      error_d     = 1'b0;
      err_count_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      delay_q     <= AW'(1);
      fill_cnt_q  <= '0;
      gen_base_q  <= SEED_V;
      chk_base_q  <= SEED_V;
      vld_q       <= '0;
      out_data_q  <= '0;
      error_q     <= 1'b0;
      err_count_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      delay_q     <= delay_d;
      fill_cnt_q  <= fill_cnt_d;
      gen_base_q  <= gen_base_d;
      chk_base_q  <= chk_base_d;
      vld_q       <= vld_d;
      out_data_q  <= out_data_d;
      error_q     <= error_d;
      err_count_q <= err_count_d;
    end
  end

  bram_sdp #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_data),
    .re_i    (acc),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

endmodule

// File: tb/tb_bram_delay_line.sv
// Bench for bram_delay_line: directed stimulus, a queue-based model of the delay line
// (sample history per fill, outputs scheduled two cycles after a filled accept), one
// negedge compare process, and literal checks that pin the model.
module tb_bram_delay_line;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  cfg_delay;
  logic        cfg_load;
  logic        bist_en;
  logic        in_valid;
  logic [63:0] in_data;
  logic        out_valid;
  logic [63:0] out_data;
  logic        filled;
  logic        err_clear;
  logic        error;
  logic [15:0] err_count;

  always #5 clk = ~clk;

  bram_delay_line #(
    .DATA_W (32),
    .CH     (2),
    .DEPTH  (1024),
    .SEED   (500)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cfg_delay (cfg_delay),
    .cfg_load  (cfg_load),
    .bist_en   (bist_en),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .filled    (filled),
    .err_clear (err_clear),
    .error     (error),
    .err_count (err_count)
  );

  typedef struct {
    int          due;
    logic [63:0] data;
  } exp_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  int          obs_cnt = 0;
  int          obs_start;
  exp_t        q[$];
  logic [63:0] hist[$];
  int          m_delay  = 1;
  logic        m_err    = 1'b0;
  logic [15:0] m_cnt    = '0;
  logic [63:0] last_out = '0;
  logic        skip     = 1'b0;
  logic [63:0] fv;

  function automatic void check(input string nm, input logic [63:0] act,
                                input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic logic [63:0] mk(input int c0, input int c1);
    return {c1[31:0], c0[31:0]};
  endfunction

  task automatic model_reset();
    q.delete();
    hist.delete();
    m_delay  = 1;
    m_err    = 1'b0;
    m_cnt    = '0;
    last_out = '0;
  endtask

  // One clock cycle: drive inputs, optionally corrupt out_data for this cycle, then
  // advance the model with what the DUT sampled at the edge.
  task automatic tick(input logic v, input logic [63:0] d, input logic ld, input int dl,
                      input logic clr, input logic inj);
    logic        acc;
    int          n;
    logic [63:0] smp;
    in_valid  = v;
    in_data   = d;
    cfg_load  = ld;
    cfg_delay = 10'(dl);
    err_clear = clr;
    if (inj) begin
      fv   = out_data ^ 64'h1;
      force dut.out_data = fv;
      skip = 1'b1;
    end
    @(posedge clk);
    if (!reset) begin
      acc = bist_en | v;
      if (ld) begin
        while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
        m_delay = (dl == 0) ? 1 : dl;
        hist.delete();
      end
      if (acc) begin
        n   = hist.size();
        smp = bist_en ? mk(500 + n, 501 + n) : d;
        if (n >= m_delay) q.push_back('{cyc + 2, hist[n - m_delay]});
        hist.push_back(smp);
      end
      if (inj) begin
        m_err = 1'b1;
        m_cnt = clr ? 16'd1 : ((m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1);
      end else if (clr) begin
        m_err = 1'b0;
        m_cnt = '0;
      end
    end
    cyc++;
    #1;
    if (inj) begin
      release dut.out_data;
      skip = 1'b0;
    end
    cfg_load  = 1'b0;
    err_clear = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 64'h0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    logic ev;
    ev = (q.size() > 0 && q[0].due == cyc);
    check("out_valid", {63'h0, out_valid}, {63'h0, ev});
    if (ev) begin
      last_out = q[0].data;
      void'(q.pop_front());
    end
    if (out_valid) obs_cnt++;
    if (!skip) check("out_data", out_data, last_out);
    check("filled", {63'h0, filled}, {63'h0, hist.size() >= m_delay});
    check("error", {63'h0, error}, {63'h0, m_err});
    check("err_count", {48'h0, err_count}, {48'h0, m_cnt});
  end

  initial begin
    reset = 1'b1; bist_en = 1'b0; in_valid = 1'b0; in_data = '0;
    cfg_load = 1'b0; cfg_delay = '0; err_clear = 1'b0;
    idle(10);
    check("rst_out_valid", {63'h0, out_valid}, 64'h0);
    check("rst_filled", {63'h0, filled}, 64'h0);
    check("rst_err", {47'h0, error, err_count}, 64'h0);
    check("rst_out_data", out_data, 64'h0);
    reset = 1'b0;

    // Delay 4, continuous stream.
    tick(1'b0, 64'h0, 1'b1, 4, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b1, mk(100 + i, 1000 + i), 1'b0, 4, 1'b0, 1'b0);
    check("t1_not_yet", {63'h0, out_valid}, 64'h0);
    tick(1'b1, mk(105, 1005), 1'b0, 4, 1'b0, 1'b0);
    check("t1_first_valid", {63'h0, out_valid}, 64'h1);
    check("t1_first_data", out_data, mk(100, 1000));
    for (int i = 6; i < 12; i++) tick(1'b1, mk(100 + i, 1000 + i), 1'b0, 4, 1'b0, 1'b0);
    check("t1_later_data", out_data, mk(106, 1006));
    check("t1_filled", {63'h0, filled}, 64'h1);
    idle(3);

    // Delay 3, gapped input 1,0,1,1,0.
    tick(1'b0, 64'h0, 1'b1, 3, 1'b0, 1'b0);
    obs_start = obs_cnt;
    begin
      int k;
      k = 0;
      for (int i = 0; i < 20; i++) begin
        logic p;
        p = ((i % 5) == 0) || ((i % 5) == 2) || ((i % 5) == 3);
        tick(p, mk(200 + k, 'hA00 + k), 1'b0, 3, 1'b0, 1'b0);
        if (p) k++;
      end
    end
    idle(3);
    check("t2_out_count", 64'(obs_cnt - obs_start), 64'd9);
    check("t2_model_last", last_out, mk(208, 'hA08));
    check("t2_dut_hold", out_data, mk(208, 'hA08));

    // Mid-stream load with delay 0, data path.
    for (int i = 0; i < 6; i++) tick(1'b1, mk(300 + i, 'hB00 + i), 1'b0, 3, 1'b0, 1'b0);
    tick(1'b1, mk(400, 'hC00), 1'b1, 0, 1'b0, 1'b0);
    check("t5_squash", {63'h0, out_valid}, 64'h0);
    tick(1'b1, mk(401, 'hC01), 1'b0, 0, 1'b0, 1'b0);
    check("t5_gap", {63'h0, out_valid}, 64'h0);
    tick(1'b1, mk(402, 'hC02), 1'b0, 0, 1'b0, 1'b0);
    check("t5_resume_valid", {63'h0, out_valid}, 64'h1);
    check("t5_resume_data", out_data, mk(400, 'hC00));
    tick(1'b1, mk(403, 'hC03), 1'b0, 0, 1'b0, 1'b0);
    check("t5_next_data", out_data, mk(401, 'hC01));
    idle(3);

    // BIST at delay 1000, wrapping the pointer.
    bist_en = 1'b1;
    tick(1'b0, 64'h0, 1'b1, 1000, 1'b0, 1'b0);
    for (int i = 1; i < 1200; i++) tick(1'b0, 64'h0, 1'b0, 1000, 1'b0, 1'b0);
    check("t3_data", out_data, mk(698, 699));
    check("t3_valid", {63'h0, out_valid}, 64'h1);
    check("t3_err", {47'h0, error, err_count}, 64'h0);

    // Injected mismatches and clear.
    tick(1'b0, 64'h0, 1'b0, 1000, 1'b0, 1'b1);
    check("t4_err1", {47'h0, error, err_count}, {47'h0, 1'b1, 16'd1});
    tick(1'b0, 64'h0, 1'b0, 1000, 1'b0, 1'b0);
    check("t4_sticky", {47'h0, error, err_count}, {47'h0, 1'b1, 16'd1});
    tick(1'b0, 64'h0, 1'b0, 1000, 1'b0, 1'b1);
    check("t4_err2", {47'h0, error, err_count}, {47'h0, 1'b1, 16'd2});
    tick(1'b0, 64'h0, 1'b0, 1000, 1'b1, 1'b0);
    check("t4_clear", {47'h0, error, err_count}, 64'h0);
    tick(1'b0, 64'h0, 1'b0, 1000, 1'b0, 1'b1);
    check("t4_err_again", {47'h0, error, err_count}, {47'h0, 1'b1, 16'd1});
    tick(1'b0, 64'h0, 1'b0, 1000, 1'b1, 1'b1);
    check("t4_clear_vs_err", {47'h0, error, err_count}, {47'h0, 1'b1, 16'd1});

    // BIST mid-stream load with delay 0.
    tick(1'b0, 64'h0, 1'b0, 1000, 1'b1, 1'b0);
    tick(1'b0, 64'h0, 1'b1, 0, 1'b0, 1'b0);
    check("t5b_squash", {63'h0, out_valid}, 64'h0);
    for (int i = 1; i < 21; i++) tick(1'b0, 64'h0, 1'b0, 0, 1'b0, 1'b0);
    check("t5b_data", out_data, mk(518, 519));
    check("t5b_err", {47'h0, error, err_count}, 64'h0);

    // Asynchronous reset mid-stream.
    tick(1'b0, 64'h0, 1'b0, 0, 1'b0, 1'b1);
    tick(1'b0, 64'h0, 1'b0, 0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("t6_async_valid", {63'h0, out_valid}, 64'h0);
    check("t6_async_err", {47'h0, error, err_count}, 64'h0);
    check("t6_async_filled", {63'h0, filled}, 64'h0);
    check("t6_async_data", out_data, 64'h0);
    model_reset();
    idle(2);
    reset = 1'b0;
    tick(1'b0, 64'h0, 1'b0, 0, 1'b0, 1'b0);
    check("t6_refill", {63'h0, filled}, 64'h1);
    tick(1'b0, 64'h0, 1'b0, 0, 1'b0, 1'b0);
    check("t6_not_yet", {63'h0, out_valid}, 64'h0);
    tick(1'b0, 64'h0, 1'b0, 0, 1'b0, 1'b0);
    check("t6_first", out_data, mk(500, 501));
    idle(5);
    check("t6_err", {47'h0, error, err_count}, 64'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_delay_line.md
Name: bram_delay_line

Overview:
Parametrised multi-channel BRAM delay line. It delays a valid-qualified sample stream by a run-time programmable number of samples. A built-in self-test (BIST) mode drives an internal pattern into the delay and checks the delayed output, with a sticky error flag and an error counter. It sits between sample sources and consumers that need fixed sample-aligned delay, and doubles as an on-chip BRAM integrity checker.

Parameters:
DATA_W, 32, width of one channel sample
CH, 2, number of parallel channels sharing one address pointer
DEPTH, 1024, buffer depth in samples; must be a power of 2
AW, $clog2(DEPTH), address/delay width (derived, not overridden)
SEED, 500, BIST pattern start value

Ports:
clk  in  1  system clock; all logic on rising edge
reset  in  1  asynchronous, active-high reset
cfg_delay  in  AW  delay in samples; 0 treated as 1; maximum DEPTH-1
cfg_load  in  1  one-cycle pulse: latch cfg_delay and restart fill
bist_en  in  1  1 = internal pattern source and checker active
in_valid  in  1  input sample strobe (ignored when bist_en=1)
in_data  in  CH*DATA_W  input samples; channel c at bits [c*DATA_W +: DATA_W]
out_valid  out  1  output sample strobe
out_data  out  CH*DATA_W  delayed samples
filled  out  1  buffer holds at least delay samples
err_clear  in  1  pulse: clear error and err_count
error  out  1  sticky BIST mismatch flag
err_count  out  16  saturating BIST mismatch count

Behaviour:
- Reset (async assert, sync release): wr_ptr=0, delay_r=1, fill_cnt=0, gen_base=SEED, chk_base=SEED. All outputs are 0.
- Accept strobe acc = bist_en ? 1 : in_valid. On acc: write the sample at wr_ptr, read at (wr_ptr - delay_r) mod DEPTH, wr_ptr++ (wraps at DEPTH).
- Read and write addresses never coincide because delay_r >= 1, so there is no read-during-write hazard.
- fill_cnt counts accepted samples and saturates at delay_r. filled = (fill_cnt == delay_r).
- Latency: if the k-th accepted sample is accepted in cycle t, and filled was already 1 before that accept, out_valid=1 in cycle t+2 with out_data = sample k-delay_r. The two stages are BRAM registered read plus the output register.
- out_data holds its last value when out_valid=0.
- No accept means no output and no pointer movement. Gaps in in_valid reproduce as identical gaps at the output.
- cfg_load:
  - delay_r <= max(cfg_delay,1) next cycle; fill_cnt, gen_base and chk_base re-initialise.
  - In-flight pipeline valids are squashed, so out_valid=0 from the next cycle until refill completes.
  - wr_ptr is not reset.
  - cfg_load together with acc: the sample is written and counts as the first sample of the new fill.
- BIST generator: channel c sample = gen_base + c (DATA_W wrap-around). gen_base increments on every acc.
- BIST checker:
  - On each out_valid with bist_en=1, compare channel c against chk_base + c, then chk_base++.
  - Any channel mismatch sets error=1 and increments err_count by 1 per cycle, saturating at 16'hFFFF.
- err_clear clears error and err_count. If err_clear and a mismatch occur in the same cycle, the mismatch wins: error=1, err_count=1.
- Toggling bist_en mid-stream without cfg_load is undefined for the checker only; data path behaviour is unaffected.
- Reset mid-operation: outputs drop to 0 immediately, and fill restarts after release.

Decomposition:
- Package bram_delay_pkg:
  - ERRCNT_W=16
  - pipeline latency constant RD_LAT=2
  - function clamp_delay(x) returning max(x,1)
  - typedef of the per-channel sample type
- One sub-module, bram_sdp: simple dual-port RAM with one write port and one registered read port, width CH*DATA_W, depth DEPTH, inferred block RAM.
- Top-level holds pointers, fill logic, generator, checker and the output register.

Test Plan:
1. Reset 10 cycles, bist_en=0, cfg_delay=4 with cfg_load, in_data ch0=100,101,... every cycle -> first out_valid 2 cycles after the 5th input, ch0=100, ch1 as driven; then consecutive values, filled=1.
2. in_valid pattern 1,0,1,1,0 at delay 3 -> output values in the same order, out_valid gaps mirror input gaps, no value skipped or repeated.
3. bist_en=1, cfg_delay=1000, DEPTH=1024, run 1200 cycles past reset (wraps the pointer) -> error=0, err_count=0, ch0 out sequence 500,501,... and ch1=ch0+1.
4. BIST running; bench forces one out_data bit for one cycle -> error=1, err_count=1. err_clear pulse -> both 0. Forced mismatch coincident with err_clear -> error=1, err_count=1.
5. Mid-stream cfg_load with cfg_delay=0 -> out_valid=0 next cycle, delay treated as 1, output resumes 2 cycles after the second accepted sample with correct ordering. In BIST mode, no error is raised.
6. Assert reset mid-stream -> out_valid, error, err_count, filled = 0 in the same cycle without waiting for an edge. After release, fill restarts with delay 1.
